// File: rtl/lpif_dstrm_pkg.sv
// Shared types for the LPIF downstream master transmitter: link word layout and FSM encoding.
package lpif_dstrm_pkg;

    localparam int LPIF_DSTRM_W = 77;

    typedef struct packed {
        logic [3:0]  state;
        logic [1:0]  protid;
        logic [63:0] data;
        logic        dvalid;
        logic [3:0]  crc;
        logic        crc_valid;
        logic        valid;
    } lpif_dstrm_word_t;

    typedef enum logic [1:0] {
        OFFLINE = 2'd0,
        SYNC    = 2'd1,
        ONLINE  = 2'd2
    } fsm_e;

    function automatic lpif_dstrm_word_t idle_word(input logic [3:0] st);
        lpif_dstrm_word_t w;
        w       = '0;
        w.state = st;
        return w;
    endfunction

endpackage

// File: rtl/lpif_sync_fifo.sv
// Single-clock FIFO with synchronous flush; head shows the oldest entry whenever count>0.
module lpif_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/lpif_dstrm_master_tx.sv
// LPIF downstream master transmitter: buffers user words and emits 77-bit link words.
// Optional LPIF_DSTRM_TX_STATS_EN builds a popped-data-word counter shown in debug[7:0].
module lpif_dstrm_master_tx
    import lpif_dstrm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr_n,
    input  logic                    tx_online,
    input  logic [3:0]              dstrm_state,
    input  logic [1:0]              dstrm_protid,
    input  logic [63:0]             dstrm_data,
    input  logic                    dstrm_dvalid,
    input  logic [3:0]              dstrm_crc,
    input  logic                    dstrm_crc_valid,
    input  logic                    dstrm_valid,
    output logic                    dstrm_ready,
    input  logic                    link_ready,
    output logic [LPIF_DSTRM_W-1:0] tx_downstream_data,
    output logic [31:0]             tx_downstream_debug_status
);

    fsm_e             fsm;
    logic [3:0]       last_state;
    logic [7:0]       drop_cnt;
    logic             overflow_sticky;
    logic [CNT_W-1:0] count;
    logic [7:0]       word_cnt;
    lpif_dstrm_word_t in_word, head_word;
    logic             push, pop, flush;
    logic [8:0]       drop_sum;

    assign in_word     = {dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
                          dstrm_crc, dstrm_crc_valid, dstrm_valid};
    assign dstrm_ready = (fsm == ONLINE) && (count < CNT_W'(DEPTH));
    // Losing tx_online overrides every other event in the same cycle.
    assign flush       = !tx_online;
    assign push        = tx_online && dstrm_valid && dstrm_ready;
    assign pop         = tx_online && (fsm == ONLINE) && link_ready && (count != '0);
    assign drop_sum    = {1'b0, drop_cnt} + 9'(count);

    lpif_sync_fifo #(.WIDTH(LPIF_DSTRM_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk_wr),
        .rst_n (rst_wr_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (in_word),
        .head  (head_word),
        .count (count)
    );

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            fsm                <= OFFLINE;
            tx_downstream_data <= '0;
            last_state         <= 4'h0;
            drop_cnt           <= 8'h0;
            overflow_sticky    <= 1'b0;
        end else if (!tx_online) begin
            fsm                <= OFFLINE;
            tx_downstream_data <= '0;
            drop_cnt           <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end else begin
            case (fsm)
                OFFLINE: fsm <= SYNC;
                default: fsm <= ONLINE;
            endcase
            if (link_ready) begin
                case (fsm)
                    ONLINE:  tx_downstream_data <= pop ? head_word : idle_word(last_state);
                    SYNC:    tx_downstream_data <= idle_word(last_state);
                    default: tx_downstream_data <= '0;
                endcase
            end
            // State-only changes must reach the link even when no data is pushed.
            if (push)
                last_state <= dstrm_state;
            else if (fsm == ONLINE && !dstrm_valid && dstrm_state != last_state)
                last_state <= dstrm_state;
            if (fsm == ONLINE && dstrm_valid && count == CNT_W'(DEPTH))
                overflow_sticky <= 1'b1;
        end
    end

`ifdef LPIF_DSTRM_TX_STATS_EN
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n)      word_cnt <= 8'h0;
        else if (!tx_online) word_cnt <= 8'h0;
        else if (pop)        word_cnt <= word_cnt + 8'h1;
    end
`else
    assign word_cnt = 8'h0;
`endif

    assign tx_downstream_debug_status = {fsm, overflow_sticky, tx_online, 4'b0,
                                         drop_cnt, 8'(count), word_cnt};

endmodule
